perceptron_bp_engine: RTL and testbench

- Sequential, parametrised successor to the combinational B-instruction perceptron predict/learn stage in the fetch path.
- Holds its own weight table, global history register (GHR) and pending-branch FIFO.
- Predicts up to N_BR consecutive B instructions per fetch group, trains weights on in-order resolution, and repairs speculative history on mispredict.
- Sits between fetch-group decode (which supplies the B count) and the next-PC select logic.

---
 rtl/perceptron_bp_engine.sv | 256 +++++++++++++++++++++++++
 tb/tb_perceptron_bp_engine.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/perceptron_bp_engine.sv
// perceptron_bp_engine: sequential perceptron branch predictor for fetch groups.
// Predicts up to N_BR consecutive B instructions per group against a weight
// table indexed by PC, keeps a speculative global history register, queues
// every passed branch in a pending FIFO, and trains in order on resolution.
// Optional feature macro: PERCEPTRON_THETA_TRAIN_EN (also train on |sum| <= THETA).
module perceptron_bp_engine #(
  parameter int N_BR       = 4,
  parameter int HIST_LEN   = 8,
  parameter int WEIGHT_W   = 8,
  parameter int N_TABLE    = 16,
  parameter int PEND_DEPTH = 8,
  parameter int THETA      = 14
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_predValid,
  output logic                o_predReady,
  input  logic [31:0]         i_pc_32,
  input  logic [3:0]          i_bCount_4,
  output logic                o_predOutValid,
  output logic                o_predGotJ,
  output logic [3:0]          o_firstTakenIdx_4,
  output logic [3:0]          o_passBNum_4,
  input  logic                i_resValid,
  input  logic                i_resTaken,
  output logic                o_resReady,
  output logic                o_flush,
  output logic [HIST_LEN-1:0] o_ghr
);
  localparam int IDX_W = (N_TABLE > 1) ? $clog2(N_TABLE) : 1;
  localparam int SUM_W = WEIGHT_W + $clog2(HIST_LEN + 2);
  localparam int PTR_W = (PEND_DEPTH > 1) ? $clog2(PEND_DEPTH) : 1;
  localparam int CNT_W = $clog2(PEND_DEPTH + 1);
  localparam int NW    = HIST_LEN + 1;
  localparam logic signed [WEIGHT_W-1:0] W_MAX = {1'b0, {(WEIGHT_W-1){1'b1}}};
  localparam logic signed [WEIGHT_W-1:0] W_MIN = {1'b1, {(WEIGHT_W-1){1'b0}}};
  localparam logic signed [WEIGHT_W-1:0] W_ONE = WEIGHT_W'(1);

  typedef enum logic {IDLE = 1'b0, TRAIN = 1'b1} stateT;
  stateT state, stateNext;

  logic signed [WEIGHT_W-1:0] weights [N_TABLE][NW];
  logic [HIST_LEN-1:0]        ghr;

  logic [IDX_W-1:0]    fIdx  [PEND_DEPTH];
  logic [HIST_LEN-1:0] fHist [PEND_DEPTH];
  logic                fPred [PEND_DEPTH];
  logic [PTR_W-1:0]    rdPtr, wrPtr;
  logic [CNT_W-1:0]    cnt;

  logic [IDX_W-1:0]    trnIdx_p1;
  logic [HIST_LEN-1:0] trnHist_p1;
  logic                trnPred_p1, trnActual_p1;
`ifdef PERCEPTRON_THETA_TRAIN_EN
  logic [SUM_W-1:0]    fAbs [PEND_DEPTH];
  logic [SUM_W-1:0]    trnAbs_p1;
`endif

  logic                vld_p1, gotJ_p1;
  logic [3:0]          firstIdx_p1, passNum_p1;

  logic                predAcc, resAcc, mispred, doTrain;

  function automatic logic signed [SUM_W-1:0] sext(input logic signed [WEIGHT_W-1:0] w);
    return {{(SUM_W-WEIGHT_W){w[WEIGHT_W-1]}}, w};
  endfunction

  function automatic logic signed [SUM_W-1:0] dotSum(input logic [IDX_W-1:0] idx,
                                                     input logic [HIST_LEN-1:0] h);
    logic signed [SUM_W-1:0] acc;
    acc = sext(weights[idx][0]);
    for (int i = 0; i < HIST_LEN; i++)
      acc = h[i] ? acc + sext(weights[idx][i+1]) : acc - sext(weights[idx][i+1]);
    return acc;
  endfunction

  function automatic logic signed [WEIGHT_W-1:0] satStep(input logic signed [WEIGHT_W-1:0] w,
                                                         input logic up);
    if (up) return (w == W_MAX) ? w : w + W_ONE;
    return (w == W_MIN) ? w : w - W_ONE;
  endfunction

  function automatic logic [PTR_W-1:0] ptrAdd(input logic [PTR_W-1:0] p, input int n);
    int t;
    t = (int'(p) + n) % PEND_DEPTH;
    return PTR_W'(t);
  endfunction

`ifdef PERCEPTRON_THETA_TRAIN_EN
  function automatic logic [SUM_W-1:0] absMag(input logic signed [SUM_W-1:0] v);
    return v[SUM_W-1] ? SUM_W'(-v) : SUM_W'(v);
  endfunction
`endif

  logic [IDX_W-1:0]        slotIdx  [N_BR];
  logic [HIST_LEN-1:0]     slotHist [N_BR];
  logic signed [SUM_W-1:0] slotSum  [N_BR];
  logic [3:0]              bEff, firstIdx, passNum;
  logic                    gotJ;
  logic [HIST_LEN-1:0]     ghrPred;

  // Per-slot perceptron sums; earlier slots are treated as not-taken in the history
  always_comb begin
    bEff     = (i_bCount_4 > 4'(N_BR)) ? 4'(N_BR) : i_bCount_4;
    gotJ     = 1'b0;
    firstIdx = 4'hF;
    passNum  = bEff;
    for (int s = 0; s < N_BR; s++) begin
      slotIdx[s]  = i_pc_32[2 +: IDX_W] + IDX_W'(s);
      slotHist[s] = ghr << s;
      slotSum[s]  = dotSum(slotIdx[s], slotHist[s]);
      if (!gotJ && (4'(s) < bEff) && !slotSum[s][SUM_W-1]) begin
        gotJ     = 1'b1;
        firstIdx = 4'(s);
        passNum  = 4'(s + 1);
      end
    end
    ghrPred = (ghr << passNum) | HIST_LEN'(gotJ);
  end

  assign mispred = (trnPred_p1 != trnActual_p1);
`ifdef PERCEPTRON_THETA_TRAIN_EN
  assign doTrain = mispred || (trnAbs_p1 <= SUM_W'(THETA));
`else
  assign doTrain = mispred;
`endif

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= stateNext;
  end

  // FSM next state and handshake/flush decode
  always_comb begin
    stateNext   = state;
    o_predReady = 1'b0;
    o_resReady  = 1'b0;
    o_flush     = 1'b0;
    case (state)
      IDLE: begin
        o_predReady = (CNT_W'(PEND_DEPTH) - cnt) >= CNT_W'(N_BR);
        o_resReady  = (cnt != '0);
        if (i_resValid && o_resReady) stateNext = TRAIN;
      end
      TRAIN: begin
        o_flush   = mispred;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign predAcc = i_predValid && o_predReady;
  assign resAcc  = i_resValid && o_resReady;

  // History and FIFO pointers: speculative update on accept, repair/clear on mispredict
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ghr   <= '0;
      rdPtr <= '0;
      wrPtr <= '0;
      cnt   <= '0;
    end else if (state == TRAIN) begin
      if (mispred) begin
        ghr   <= (trnHist_p1 << 1) | HIST_LEN'(trnActual_p1);
        rdPtr <= '0;
        wrPtr <= '0;
        cnt   <= '0;
      end
    end else begin
      if (predAcc) begin
        ghr   <= ghrPred;
        wrPtr <= ptrAdd(wrPtr, int'(passNum));
      end
      if (resAcc) rdPtr <= ptrAdd(rdPtr, 1);
      cnt <= CNT_W'(int'(cnt) + (predAcc ? int'(passNum) : 0) - (resAcc ? 1 : 0));
    end
  end

  // Stage p0 -> p1: registered prediction result
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      vld_p1      <= 1'b0;
      gotJ_p1     <= 1'b0;
      firstIdx_p1 <= '0;
      passNum_p1  <= '0;
    end else begin
      vld_p1 <= predAcc;
      if (predAcc) begin
        gotJ_p1     <= gotJ;
        firstIdx_p1 <= firstIdx;
        passNum_p1  <= passNum;
      end
    end
  end

  // Pending FIFO storage: one entry per passed B
  always_ff @(posedge i_clk) begin
    for (int s = 0; s < N_BR; s++) begin
      if (predAcc && (4'(s) < passNum)) begin
        fIdx[ptrAdd(wrPtr, s)]  <= slotIdx[s];
        fHist[ptrAdd(wrPtr, s)] <= slotHist[s];
        fPred[ptrAdd(wrPtr, s)] <= !slotSum[s][SUM_W-1];
`ifdef PERCEPTRON_THETA_TRAIN_EN
        fAbs[ptrAdd(wrPtr, s)]  <= absMag(slotSum[s]);
`endif
      end
    end
  end

  // Stage p0 -> p1: oldest entry and outcome captured for training
  always_ff @(posedge i_clk) begin
    if (resAcc) begin
      trnIdx_p1    <= fIdx[rdPtr];
      trnHist_p1   <= fHist[rdPtr];
      trnPred_p1   <= fPred[rdPtr];
      trnActual_p1 <= i_resTaken;
`ifdef PERCEPTRON_THETA_TRAIN_EN
      trnAbs_p1    <= fAbs[rdPtr];
`endif
    end
  end

  // Weight table: cleared on reset, saturating update at the end of TRAIN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int e = 0; e < N_TABLE; e++)
        for (int i = 0; i < NW; i++)
          weights[e][i] <= '0;
    end else if (state == TRAIN && doTrain) begin
      weights[trnIdx_p1][0] <= satStep(weights[trnIdx_p1][0], trnActual_p1);
      for (int i = 0; i < HIST_LEN; i++)
        weights[trnIdx_p1][i+1] <= satStep(weights[trnIdx_p1][i+1],
                                           trnHist_p1[i] == trnActual_p1);
    end
  end

  // Sink for PC bits outside the index and values only the threshold build consumes
  logic unusedBits;
  always_comb begin
    unusedBits = ^{i_pc_32[31:2+IDX_W], i_pc_32[1:0]};
`ifndef PERCEPTRON_THETA_TRAIN_EN
    unusedBits = unusedBits ^ (THETA != 0);
    for (int s = 0; s < N_BR; s++)
      unusedBits = unusedBits ^ (^slotSum[s][SUM_W-2:0]);
`endif
  end

  assign o_predOutValid    = vld_p1;
  assign o_predGotJ        = gotJ_p1;
  assign o_firstTakenIdx_4 = firstIdx_p1;
  assign o_passBNum_4      = passNum_p1;
  assign o_ghr             = ghr;

endmodule

// File: tb/tb_perceptron_bp_engine.sv
// Testbench for perceptron_bp_engine: directed scenarios with hand-computed
// expectations, then randomized traffic compared cycle by cycle against a
// behavioural model (weight array, history integer, pending queue).
module tb_perceptron_bp_engine;
  localparam int NBR = 4, HL = 8, NT = 16, PD = 8, TH = 14;

  logic        i_clk = 1'b0;
  logic        i_rst_n, i_predValid, i_resValid, i_resTaken;
  logic [31:0] i_pc_32;
  logic [3:0]  i_bCount_4;
  logic        o_predReady, o_predOutValid, o_predGotJ, o_resReady, o_flush;
  logic [3:0]  o_firstTakenIdx_4, o_passBNum_4;
  logic [HL-1:0] o_ghr;

  perceptron_bp_engine #(.N_BR(NBR), .HIST_LEN(HL), .WEIGHT_W(8), .N_TABLE(NT),
                         .PEND_DEPTH(PD), .THETA(TH)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_predValid(i_predValid), .o_predReady(o_predReady),
    .i_pc_32(i_pc_32), .i_bCount_4(i_bCount_4), .o_predOutValid(o_predOutValid),
    .o_predGotJ(o_predGotJ), .o_firstTakenIdx_4(o_firstTakenIdx_4), .o_passBNum_4(o_passBNum_4),
    .i_resValid(i_resValid), .i_resTaken(i_resTaken), .o_resReady(o_resReady),
    .o_flush(o_flush), .o_ghr(o_ghr));

  always #5 i_clk = ~i_clk;

  int nChecks = 0, nErrors = 0;

  typedef struct { int idx; int hist; int absSum; bit pred; } entT;
  entT q[$];
  int  mW [NT][HL+1];
  int  mGhr;
  bit  mTrain, mAct;
  entT mEnt;
  bit  mVld, mGotJ, mFresh;
  int  mFirst, mPass;
  bit  cmpOn = 0;

  task automatic chk(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nErrors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int clampW(input int v);
    return (v > 127) ? 127 : ((v < -128) ? -128 : v);
  endfunction

  function automatic int mSum(input int idx, input int h);
    int s;
    s = mW[idx][0];
    for (int i = 0; i < HL; i++)
      s += ((h >> i) & 1) ? mW[idx][i+1] : -mW[idx][i+1];
    return s;
  endfunction

  task automatic compareAll();
    chk("predReady", int'(o_predReady), int'(!mTrain && (PD - q.size() >= NBR)));
    chk("resReady", int'(o_resReady), int'(!mTrain && q.size() > 0));
    chk("flush", int'(o_flush), int'(mTrain && (mEnt.pred != mAct)));
    chk("ghr", int'(o_ghr), mGhr);
    chk("predOutValid", int'(o_predOutValid), int'(mVld));
    if (mVld || mFresh) begin
      chk("predGotJ", int'(o_predGotJ), int'(mGotJ));
      chk("firstTakenIdx", int'(o_firstTakenIdx_4), mFirst);
      chk("passBNum", int'(o_passBNum_4), mPass);
    end
  endtask

  // Model of what the coming clock edge does, from the current model state and inputs
  task automatic modelAdvance();
    bit pa, ra, misp, doTr;
    int base, n, idx, h, sm;
    entT e;
    if (!i_rst_n) begin
      foreach (mW[a, b]) mW[a][b] = 0;
      mGhr = 0; q.delete(); mTrain = 0;
      mVld = 0; mGotJ = 0; mFirst = 0; mPass = 0; mFresh = 1;
      return;
    end
    mFresh = 0;
    if (mTrain) begin
      misp = (mEnt.pred != mAct);
      doTr = misp;
`ifdef PERCEPTRON_THETA_TRAIN_EN
      if (mEnt.absSum <= TH) doTr = 1;
`endif
      if (doTr) begin
        mW[mEnt.idx][0] = clampW(mW[mEnt.idx][0] + (mAct ? 1 : -1));
        for (int i = 0; i < HL; i++)
          mW[mEnt.idx][i+1] = clampW(mW[mEnt.idx][i+1] + ((((mEnt.hist >> i) & 1) == int'(mAct)) ? 1 : -1));
      end
      if (misp) begin
        mGhr = ((mEnt.hist << 1) | int'(mAct)) & 255;
        q.delete();
      end
      mTrain = 0; mVld = 0;
      return;
    end
    pa = i_predValid && (PD - q.size() >= NBR);
    ra = i_resValid && (q.size() > 0);
    if (ra) begin
      mEnt = q.pop_front(); mAct = i_resTaken; mTrain = 1;
    end
    if (pa) begin
      base = int'((i_pc_32 >> 2) & 32'hF);
      n = int'(i_bCount_4);
      mGotJ = 0; mFirst = 15; mPass = n;
      for (int s = 0; s < n; s++) begin
        idx = (base + s) % NT;
        h = (mGhr << s) & 255;
        sm = mSum(idx, h);
        e.idx = idx; e.hist = h; e.absSum = (sm < 0) ? -sm : sm; e.pred = (sm >= 0);
        q.push_back(e);
        if (sm >= 0) begin
          mGotJ = 1; mFirst = s; mPass = s + 1;
          break;
        end
      end
      mGhr = mGotJ ? (((mGhr << mPass) | 1) & 255) : ((mGhr << n) & 255);
    end
    mVld = pa;
  endtask

  // Called at negedge+1 with inputs driven; returns at the next negedge+1
  task automatic tick();
    if (cmpOn) compareAll();
    modelAdvance();
    @(negedge i_clk);
    #1;
  endtask

  task automatic idleInputs();
    i_predValid = 0; i_resValid = 0; i_resTaken = 0; i_bCount_4 = 0; i_pc_32 = 0;
  endtask

  initial begin
    i_rst_n = 0;
    idleInputs();
    @(negedge i_clk); #1;
    tick(); tick();
    cmpOn = 1;
    // Reset state
    chk("rst_predReady", int'(o_predReady), 1);
    chk("rst_resReady", int'(o_resReady), 0);
    chk("rst_ghr", int'(o_ghr), 0);
    chk("rst_outs", int'({o_predOutValid, o_predGotJ, o_firstTakenIdx_4, o_passBNum_4, o_flush}), 0);
    i_rst_n = 1;

    // First request with zero weights: slot 0 predicts taken
    i_predValid = 1; i_pc_32 = 32'h100; i_bCount_4 = 3;
    tick();
    idleInputs();
    chk("d1_vld", int'(o_predOutValid), 1);
    chk("d1_gotJ", int'(o_predGotJ), 1);
    chk("d1_first", int'(o_firstTakenIdx_4), 0);
    chk("d1_pass", int'(o_passBNum_4), 1);
    chk("d1_ghr", int'(o_ghr), 1);
    chk("d1_modelOcc", q.size(), 1);

    // Resolve not-taken: mispredict, flush, history repair, entry 0 trained
    i_resValid = 1; i_resTaken = 0;
    tick();
    idleInputs();
    chk("d2_flush", int'(o_flush), 1);
    chk("d2_predReadyTrain", int'(o_predReady), 0);
    tick();
    chk("d2_ghr", int'(o_ghr), 0);
    chk("d2_resReady", int'(o_resReady), 0);
    chk("d2_modelBias", mW[0][0], -1);
    chk("d2_modelW1", mW[0][1], 1);
    i_predValid = 1; i_pc_32 = 32'h100; i_bCount_4 = 3;
    tick();
    idleInputs();
    chk("d2_first", int'(o_firstTakenIdx_4), 1);
    chk("d2_pass", int'(o_passBNum_4), 2);
    chk("d2_ghr2", int'(o_ghr), 1);

    // Empty group
    i_predValid = 1; i_pc_32 = 32'h200; i_bCount_4 = 0;
    tick();
    idleInputs();
    chk("d3_pass", int'(o_passBNum_4), 0);
    chk("d3_first", int'(o_firstTakenIdx_4), 15);
    chk("d3_gotJ", int'(o_predGotJ), 0);
    chk("d3_ghr", int'(o_ghr), 1);
    chk("d3_modelOcc", q.size(), 2);

    // Fill to PD-NBR+1 = 5 entries
    for (int k = 0; k < 3; k++) begin
      i_predValid = 1; i_pc_32 = 32'h8; i_bCount_4 = 1;
      tick();
    end
    idleInputs();
    chk("d4_fullReady", int'(o_predReady), 0);
    i_resValid = 1; i_resTaken = q[0].pred;
    tick();
    idleInputs();
    chk("d4_trainReady", int'(o_predReady), 0);
    chk("d4_noFlush", int'(o_flush), 0);
    tick();
    chk("d4_readyBack", int'(o_predReady), 1);

    // Drain with correct outcomes, then resolve on an empty FIFO
    for (int k = 0; k < 16 && q.size() > 0; k++) begin
      i_resValid = 1; i_resTaken = q[0].pred;
      tick();
      idleInputs();
      tick();
    end
    chk("d5_emptyResReady", int'(o_resReady), 0);
    i_resValid = 1; i_resTaken = 1;
    tick();
    idleInputs();
    chk("d5_ignoredFlush", int'(o_flush), 0);
    chk("d5_ignoredReady", int'(o_predReady), 1);

    // Repeated taken branches on one entry
    for (int k = 0; k < 200; k++) begin
      i_predValid = 1; i_pc_32 = 32'h10; i_bCount_4 = 1;
      tick();
      idleInputs();
      i_resValid = 1; i_resTaken = 1;
      tick();
      idleInputs();
      tick();
    end
`ifdef PERCEPTRON_THETA_TRAIN_EN
    chk("d6_modelBiasGrew", int'(mW[4][0] > 0 && mW[4][0] <= 127), 1);
`else
    chk("d6_modelBiasStill", mW[4][0], 0);
`endif

    // Randomized traffic including occasional resets
    for (int k = 0; k < 4000; k++) begin
      i_rst_n     = ($urandom_range(0, 99) != 0);
      i_predValid = $urandom_range(0, 1);
      i_pc_32     = ($urandom() & 32'hFFFF_FFC0) | (32'($urandom_range(0, 15)) << 2) |
                    32'($urandom_range(0, 3));
      i_bCount_4  = 4'($urandom_range(0, NBR));
      i_resValid  = $urandom_range(0, 1);
      i_resTaken  = $urandom_range(0, 1);
      tick();
    end
    i_rst_n = 1;
    idleInputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end
endmodule
